// File: rtl/aurora_rx_lane_if.sv
// Signal bundle between the deserializer, one Aurora 64B/66B receive lane and its AXI-stream sink.
// The lane is the master: it consumes raw blocks and drives slip, lock, stream and error outputs.
interface aurora_rx_lane_if;
    logic        rx_valid;
    logic [65:0] rx_data;
    logic        rx_slip;
    logic        block_lock;
    logic        axi_valid;
    logic        axi_last;
    logic [63:0] axi_data;
    logic        err_hdr;
    logic        err_frame;

    modport master (
        input  rx_valid, rx_data,
        output rx_slip, block_lock, axi_valid, axi_last, axi_data, err_hdr, err_frame
    );

    modport slave (
        output rx_valid, rx_data,
        input  rx_slip, block_lock, axi_valid, axi_last, axi_data, err_hdr, err_frame
    );
endinterface

// File: rtl/aurora_rx_lane.sv
// Single-lane Aurora 64B/66B receiver: sync-header block lock with slip, x^58+x^39+1
// descrambling, and data/idle/separator decode into a 64-bit AXI-stream with last.
module aurora_rx_lane #(
    parameter int unsigned LOCK_COUNT = 64,
    parameter int unsigned ERR_WINDOW = 64,
    parameter int unsigned ERR_LIMIT  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    aurora_rx_lane_if.master lane
);
    localparam int unsigned GW = $clog2(LOCK_COUNT + 1);
    localparam int unsigned WW = $clog2(ERR_WINDOW + 1);
    localparam int unsigned BW = $clog2(ERR_LIMIT + 1);
    localparam logic [7:0]  BTF_SEP  = 8'h1E;
    localparam logic [7:0]  BTF_IDLE = 8'h78;

    typedef enum logic {
        UNLOCKED,
        LOCKED
    } lock_state_t;

    lock_state_t   state;
    logic [GW-1:0] good_cnt;
    logic [WW-1:0] win_cnt;
    logic [BW-1:0] bad_cnt;
    logic [1:0]    skip_cnt;
    logic [57:0]   scr;
    logic [63:0]   hold;
    logic          hold_valid;

    logic [1:0]    hdr;
    logic [63:0]   c;
    logic          hdr_ok;
    logic [121:0]  e;
    logic [63:0]   d;
    logic [7:0]    btf;
    logic [WW-1:0] win_next;
    logic [BW-1:0] bad_next;

    always_comb begin
        hdr      = lane.rx_data[65:64];
        c        = lane.rx_data[63:0];
        hdr_ok   = (hdr == 2'b01) || (hdr == 2'b10);
        e        = {c, scr};
        d        = '0;
        // e[i] is the bit 58 positions back, e[i+19] the bit 39 positions back
        for (int unsigned i = 0; i < 64; i++) begin
            d[i] = c[i] ^ e[i+19] ^ e[i];
        end
        btf      = d[63:56];
        win_next = win_cnt + 1'b1;
        bad_next = bad_cnt + BW'(!hdr_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= UNLOCKED;
            good_cnt        <= '0;
            win_cnt         <= '0;
            bad_cnt         <= '0;
            skip_cnt        <= '0;
            scr             <= '0;
            hold            <= '0;
            hold_valid      <= 1'b0;
            lane.rx_slip    <= 1'b0;
            lane.block_lock <= 1'b0;
            lane.axi_valid  <= 1'b0;
            lane.axi_last   <= 1'b0;
            lane.axi_data   <= '0;
            lane.err_hdr    <= 1'b0;
            lane.err_frame  <= 1'b0;
        end else begin
            lane.rx_slip   <= 1'b0;
            lane.axi_valid <= 1'b0;
            lane.axi_last  <= 1'b0;
            lane.err_hdr   <= 1'b0;
            lane.err_frame <= 1'b0;
            if (lane.rx_valid) begin
                scr <= c[63:6];
                case (state)
                    UNLOCKED: begin
                        if (skip_cnt != 2'd0) begin
                            skip_cnt <= skip_cnt - 2'd1;
                        end else if (hdr_ok) begin
                            if (good_cnt == GW'(LOCK_COUNT - 1)) begin
                                state           <= LOCKED;
                                lane.block_lock <= 1'b1;
                                good_cnt        <= '0;
                                win_cnt         <= '0;
                                bad_cnt         <= '0;
                            end else begin
                                good_cnt <= good_cnt + 1'b1;
                            end
                        end else begin
                            good_cnt     <= '0;
                            lane.rx_slip <= 1'b1;
                            skip_cnt     <= 2'd2;
                        end
                    end
                    LOCKED: begin
                        lane.err_hdr <= !hdr_ok;
                        if (bad_next == BW'(ERR_LIMIT)) begin
                            // losing lock discards any partially received frame
                            state           <= UNLOCKED;
                            lane.block_lock <= 1'b0;
                            win_cnt         <= '0;
                            bad_cnt         <= '0;
                            good_cnt        <= '0;
                            skip_cnt        <= '0;
                            if (hold_valid) begin
                                hold_valid     <= 1'b0;
                                lane.err_frame <= 1'b1;
                            end
                        end else begin
                            if (win_next == WW'(ERR_WINDOW)) begin
                                win_cnt <= '0;
                                bad_cnt <= '0;
                            end else begin
                                win_cnt <= win_next;
                                bad_cnt <= bad_next;
                            end
                            if (hdr == 2'b01) begin
                                if (hold_valid) begin
                                    lane.axi_valid <= 1'b1;
                                    lane.axi_data  <= hold;
                                end
                                hold       <= d;
                                hold_valid <= 1'b1;
                            end else if (hdr == 2'b10) begin
                                if (btf == BTF_SEP) begin
                                    if (hold_valid) begin
                                        lane.axi_valid <= 1'b1;
                                        lane.axi_last  <= 1'b1;
                                        lane.axi_data  <= hold;
                                        hold_valid     <= 1'b0;
                                    end else begin
                                        lane.err_frame <= 1'b1;
                                    end
                                end else if (btf != BTF_IDLE) begin
                                    lane.err_frame <= 1'b1;
                                end
                            end
                        end
                    end
                    default: state <= UNLOCKED;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_aurora_rx_lane.sv
// Randomized bench for aurora_rx_lane: a serial reference scrambler feeds blocks, and a
// frame-level model predicts lock, slip, stream words and error pulses for every cycle.
module tb_aurora_rx_lane;
    localparam int unsigned LOCK_COUNT = 64;
    localparam int unsigned ERR_WINDOW = 64;
    localparam int unsigned ERR_LIMIT  = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    aurora_rx_lane_if lane();

    aurora_rx_lane #(
        .LOCK_COUNT(LOCK_COUNT),
        .ERR_WINDOW(ERR_WINDOW),
        .ERR_LIMIT (ERR_LIMIT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .lane (lane)
    );

    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned n_hdr_seen   = 0;
    int unsigned n_valid_seen = 0;
    int unsigned n_slip_seen  = 0;
    int unsigned n_frame_seen = 0;

    logic [57:0] scr;

    bit          m_locked;
    int unsigned m_good, m_skip, m_win, m_bad;
    logic [63:0] m_hold[$];

    logic        e_slip, e_hdr, e_frame, e_valid, e_last;
    logic [63:0] e_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] ctrl(input logic [7:0] btf);
        logic [63:0] t;
        t = rand64();
        return {btf, t[55:0]};
    endfunction

    // serial scrambler, scr[0] is the most recently transmitted bit
    task automatic scramble(input logic [63:0] p, output logic [63:0] c);
        logic o;
        for (int i = 0; i < 64; i++) begin
            o    = p[i] ^ scr[38] ^ scr[57];
            c[i] = o;
            scr  = {scr[56:0], o};
        end
    endtask

    task automatic clear_expect();
        e_slip = 1'b0; e_hdr = 1'b0; e_frame = 1'b0;
        e_valid = 1'b0; e_last = 1'b0; e_data = '0;
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_good = 0; m_skip = 0; m_win = 0; m_bad = 0;
        m_hold.delete();
        clear_expect();
    endtask

    task automatic emit(input logic last);
        e_valid = 1'b1;
        e_last  = last;
        e_data  = m_hold.pop_front();
    endtask

    task automatic model_block(input logic [1:0] hdr, input logic [63:0] plain);
        bit ok;
        clear_expect();
        ok = (hdr == 2'b01) || (hdr == 2'b10);
        if (!m_locked) begin
            if (m_skip > 0) begin
                m_skip--;
            end else if (ok) begin
                m_good++;
                if (m_good == LOCK_COUNT) begin
                    m_locked = 1'b1;
                    m_good = 0; m_win = 0; m_bad = 0;
                end
            end else begin
                m_good = 0;
                e_slip = 1'b1;
                m_skip = 2;
            end
        end else begin
            e_hdr = !ok;
            m_win++;
            if (!ok) m_bad++;
            if (m_bad == ERR_LIMIT) begin
                m_locked = 1'b0;
                m_good = 0; m_win = 0; m_bad = 0; m_skip = 0;
                if (m_hold.size() != 0) begin
                    m_hold.delete();
                    e_frame = 1'b1;
                end
            end else begin
                if (m_win == ERR_WINDOW) begin
                    m_win = 0;
                    m_bad = 0;
                end
                if (hdr == 2'b01) begin
                    if (m_hold.size() != 0) emit(1'b0);
                    m_hold.push_back(plain);
                end else if (hdr == 2'b10) begin
                    if (plain[63:56] == 8'h1E) begin
                        if (m_hold.size() != 0) emit(1'b1);
                        else e_frame = 1'b1;
                    end else if (plain[63:56] != 8'h78) begin
                        e_frame = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        if (lane.err_hdr)   n_hdr_seen++;
        if (lane.axi_valid) n_valid_seen++;
        if (lane.rx_slip)   n_slip_seen++;
        if (lane.err_frame) n_frame_seen++;
        check("rx_slip",    64'(lane.rx_slip),    64'(e_slip));
        check("block_lock", 64'(lane.block_lock), 64'(m_locked));
        check("axi_valid",  64'(lane.axi_valid),  64'(e_valid));
        check("axi_last",   64'(lane.axi_last),   64'(e_last));
        if (e_valid) check("axi_data", lane.axi_data, e_data);
        check("err_hdr",    64'(lane.err_hdr),    64'(e_hdr));
        check("err_frame",  64'(lane.err_frame),  64'(e_frame));
    endtask

    task automatic send(input logic [1:0] hdr, input logic [63:0] plain);
        logic [63:0] c;
        @(negedge clk);
        scramble(plain, c);
        lane.rx_valid = 1'b1;
        lane.rx_data  = {hdr, c};
        model_block(hdr, plain);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic gap();
        logic [63:0] t;
        @(negedge clk);
        t = rand64();
        lane.rx_valid = 1'b0;
        lane.rx_data  = {2'b11, t};
        clear_expect();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_slip"},  64'(lane.rx_slip),    64'd0);
        check({tag, "_lock"},  64'(lane.block_lock), 64'd0);
        check({tag, "_valid"}, 64'(lane.axi_valid),  64'd0);
        check({tag, "_last"},  64'(lane.axi_last),   64'd0);
        check({tag, "_data"},  lane.axi_data,        64'd0);
        check({tag, "_hdr"},   64'(lane.err_hdr),    64'd0);
        check({tag, "_frame"}, 64'(lane.err_frame),  64'd0);
    endtask

    initial begin
        logic [63:0] t;
        int unsigned base_hdr, base_valid, base_slip, base_frame;

        lane.rx_valid = 1'b0;
        lane.rx_data  = '0;
        t   = rand64();
        scr = t[57:0];
        model_reset();

        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // acquire lock; no stream output may appear before it
        base_valid = n_valid_seen;
        for (int i = 0; i < 63; i++) send(2'b01, rand64());
        check("lock_before_64", 64'(lane.block_lock), 64'd0);
        send(2'b01, rand64());
        check("lock_after_64", 64'(lane.block_lock), 64'd1);
        check("no_valid_prelock", 64'(n_valid_seen - base_valid), 64'd0);

        // words 1,2,3 then separator
        send(2'b01, 64'd1);
        send(2'b01, 64'd2);
        check("word1", lane.axi_data, 64'd1);
        send(2'b01, 64'd3);
        check("word2", lane.axi_data, 64'd2);
        send(2'b10, {8'h1E, 56'd0});
        check("word3", lane.axi_data, 64'd3);
        check("word3_last", 64'(lane.axi_last), 64'd1);

        // idles inside a frame, orphan separator, unknown BTF
        send(2'b01, 64'hAAAA_0000_5555_1111);
        for (int i = 0; i < 5; i++) send(2'b10, ctrl(8'h78));
        send(2'b01, 64'hBBBB_2222_CCCC_3333);
        check("idle_a", lane.axi_data, 64'hAAAA_0000_5555_1111);
        send(2'b10, ctrl(8'h1E));
        check("idle_b", lane.axi_data, 64'hBBBB_2222_CCCC_3333);
        send(2'b10, ctrl(8'h1E));
        check("orphan_sep", 64'(lane.err_frame), 64'd1);
        send(2'b10, ctrl(8'h55));
        check("btf55_frame", 64'(lane.err_frame), 64'd1);
        check("btf55_valid", 64'(lane.axi_valid), 64'd0);

        // align to a window start, then 15 bad headers per window for 3 windows
        for (int i = 0; i < 64 && m_win != 0; i++) send(2'b10, ctrl(8'h78));
        base_hdr = n_hdr_seen;
        for (int w = 0; w < 3; w++)
            for (int j = 0; j < 64; j++)
                if (j < 15) send(2'b00, rand64());
                else        send(2'b10, ctrl(8'h78));
        check("lock_hold_3win", 64'(lane.block_lock), 64'd1);
        check("hdr_err_45", 64'(n_hdr_seen - base_hdr), 64'd45);

        base_hdr = n_hdr_seen;
        for (int j = 0; j < 16; j++) send(2'b00, rand64());
        check("hdr_err_16", 64'(n_hdr_seen - base_hdr), 64'd16);
        check("lock_lost", 64'(lane.block_lock), 64'd0);

        // slip: one pulse, the next two blocks are ignored
        for (int i = 0; i < 10; i++) send(2'b01, rand64());
        base_slip = n_slip_seen;
        send(2'b11, rand64());
        check("slip_pulse", 64'(lane.rx_slip), 64'd1);
        send(2'b11, rand64());
        send(2'b11, rand64());
        check("slip_once", 64'(n_slip_seen - base_slip), 64'd1);
        for (int i = 0; i < 63; i++) send(2'b10, ctrl(8'h78));
        check("relock_63", 64'(lane.block_lock), 64'd0);
        send(2'b10, ctrl(8'h78));
        check("relock_64", 64'(lane.block_lock), 64'd1);

        // held word dropped on loss of lock
        base_valid = n_valid_seen;
        base_frame = n_frame_seen;
        send(2'b01, rand64());
        for (int j = 0; j < 16; j++) send(2'b00, rand64());
        check("drop_frame_err", 64'(lane.err_frame), 64'd1);
        check("drop_no_valid", 64'(n_valid_seen - base_valid), 64'd0);
        check("drop_frame_once", 64'(n_frame_seen - base_frame), 64'd1);

        // random traffic
        for (int i = 0; i < 64; i++) send(2'b01, rand64());
        for (int i = 0; i < 1500; i++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            if      (r < 55) send(2'b01, rand64());
            else if (r < 70) send(2'b10, ctrl(8'h78));
            else if (r < 82) send(2'b10, ctrl(8'h1E));
            else if (r < 87) send(2'b10, ctrl(8'($urandom)));
            else if (r < 92) send(($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00, rand64());
            else             gap();
        end

        // asynchronous reset in the middle of a frame
        for (int i = 0; i < 200 && !m_locked; i++) send(2'b01, rand64());
        check("pre_reset_lock", 64'(lane.block_lock), 64'd1);
        send(2'b01, rand64());
        send(2'b01, rand64());
        check("pre_reset_valid", 64'(lane.axi_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        lane.rx_valid = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        base_valid = n_valid_seen;
        for (int i = 0; i < 64; i++) send(2'b01, rand64());
        check("post_reset_no_valid", 64'(n_valid_seen - base_valid), 64'd0);
        send(2'b01, 64'h0123_4567_89AB_CDEF);
        send(2'b01, 64'hFEDC_BA98_7654_3210);
        check("post_reset_w0", lane.axi_data, 64'h0123_4567_89AB_CDEF);
        send(2'b10, ctrl(8'h1E));
        check("post_reset_w1", lane.axi_data, 64'hFEDC_BA98_7654_3210);
        gap();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
